// File: rtl/sort_pkg.sv
// sort_pkg: shared constants and types for the bitonic sorter and its stages
package sort_pkg;
  localparam int WIDTH = 8;
  localparam int INDEX = 64;
  localparam logic ASC = 1'b0;
  localparam logic DESC = 1'b1;
  typedef logic [WIDTH-1:0] elem_t;
endpackage

// File: rtl/sort_slot.sv
// sort_slot: loadable INDEX x WIDTH array register with its read-order bit
module sort_slot
  import sort_pkg::*;
#(
  parameter int WIDTH = sort_pkg::WIDTH,
  parameter int INDEX = sort_pkg::INDEX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             desc_in,
  input  logic [WIDTH-1:0] din  [0:INDEX-1],
  output logic [WIDTH-1:0] dout [0:INDEX-1],
  output logic             desc
);
  logic [WIDTH-1:0] data_q [0:INDEX-1];
  logic [WIDTH-1:0] data_d [0:INDEX-1];
  logic desc_q, desc_d;
  always_comb begin
    data_d = data_q;
    desc_d = desc_q;
    if (load) begin
      data_d = din;
      desc_d = desc_in;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '{default: '0};
      desc_q <= ASC;
    end else begin
      data_q <= data_d;
      desc_q <= desc_d;
    end
  end
  assign dout = data_q;
  assign desc = desc_q;
endmodule

// File: rtl/sort_stream_out.sv
// sort_stream_out: two-slot drain stage serialising a sorted array one element per beat
module sort_stream_out
  import sort_pkg::*;
#(
  parameter int WIDTH = sort_pkg::WIDTH,
  parameter int INDEX = sort_pkg::INDEX,
  localparam int CW = $clog2(INDEX)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data [0:INDEX-1],
  input  logic             in_desc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_idx,
  output logic             out_last,
  output logic [1:0]       occupancy
);
  logic act_full_q, act_full_d, pend_full_q, pend_full_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic acc, hs, last, act_load, pend_load, act_desc, pend_desc, act_desc_in;
  logic [WIDTH-1:0] act_data [0:INDEX-1];
  logic [WIDTH-1:0] pend_data [0:INDEX-1];
  logic [WIDTH-1:0] act_din [0:INDEX-1];
  assign in_ready = !pend_full_q;
  assign acc = in_valid && in_ready;
  assign out_valid = act_full_q;
  assign hs = out_valid && out_ready;
  assign last = cnt_q == CW'(INDEX - 1);
  assign out_last = act_full_q && last;
  assign out_idx = cnt_q;
  assign out_data = act_data[act_desc == DESC ? ~cnt_q : cnt_q];
  assign occupancy = {1'b0, act_full_q} + {1'b0, pend_full_q};
  // ACTIVE refills from PENDING when one is waiting, otherwise straight from the input
  always_comb begin
    act_load = (acc && !act_full_q) || (hs && last && (pend_full_q || acc));
    pend_load = acc && act_full_q && !(hs && last);
    act_din = in_data;
    act_desc_in = in_desc;
    if (pend_full_q) begin
      act_din = pend_data;
      act_desc_in = pend_desc;
    end
    act_full_d = act_load ? 1'b1 : (hs && last) ? 1'b0 : act_full_q;
    pend_full_d = pend_load ? 1'b1 : (hs && last) ? 1'b0 : pend_full_q;
    cnt_d = hs ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      act_full_q <= 1'b0;
      pend_full_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      act_full_q <= act_full_d;
      pend_full_q <= pend_full_d;
      cnt_q <= cnt_d;
    end
  end
  sort_slot #(.WIDTH(WIDTH), .INDEX(INDEX)) u_act (
    .clk(clk), .rst(rst), .load(act_load), .desc_in(act_desc_in),
    .din(act_din), .dout(act_data), .desc(act_desc)
  );
  sort_slot #(.WIDTH(WIDTH), .INDEX(INDEX)) u_pend (
    .clk(clk), .rst(rst), .load(pend_load), .desc_in(in_desc),
    .din(in_data), .dout(pend_data), .desc(pend_desc)
  );
endmodule

// File: tb/tb_sort_stream_out.sv
// tb_sort_stream_out: scoreboard bench for the two-slot sorted-array drain stage
module tb_sort_stream_out;
  localparam int W = 8;
  localparam int N = 8;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_desc = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, out_last;
  logic [W-1:0] in_data [0:N-1];
  logic [W-1:0] arr [0:N-1];
  logic [W-1:0] out_data, hold_d;
  logic [2:0] out_idx, hold_i;
  logic [1:0] occupancy;
  logic [W+3:0] sbq [$];
  logic hold_v = 1'b0;
  logic [3:0] bp_pat = 4'b1001;
  int n_chk = 0, n_err = 0, occ_m = 0, bp = 0, cyc = 0;
  always #5 clk = ~clk;
  sort_stream_out #(.WIDTH(W), .INDEX(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_desc(in_desc), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .occupancy(occupancy)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic tick();
    logic acc;
    logic [W+3:0] e;
    out_ready = (bp == 1) ? bp_pat[cyc % 4] : (bp == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    chk("occupancy", occupancy, occ_m);
    chk("in_ready", in_ready, occ_m < 2);
    chk("out_valid", out_valid, occ_m != 0);
    if (hold_v) begin
      chk("stall_data", out_data, hold_d);
      chk("stall_idx", out_idx, hold_i);
    end
    acc = in_valid && occ_m < 2;
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) chk("unexpected_beat", 1, 0);
      else begin
        e = sbq.pop_front();
        chk("out_data", out_data, e[W+3:4]);
        chk("out_idx", out_idx, e[3:1]);
        chk("out_last", out_last, e[0]);
        if (e[0]) occ_m--;
      end
    end
    if (acc) begin
      for (int b = 0; b < N; b++)
        sbq.push_back({in_desc ? in_data[N-1-b] : in_data[b], 3'(b), b == N - 1});
      occ_m++;
    end
    hold_v = out_valid && !out_ready;
    hold_d = out_data;
    hold_i = out_idx;
    cyc++;
    @(negedge clk);
  endtask
  task automatic send(input logic d);
    logic ok = 1'b0;
    in_desc = d;
    in_data = arr;
    in_valid = 1'b1;
    for (int k = 0; k < 100 && !ok; k++) begin
      ok = occ_m < 2;
      tick();
    end
    in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 1, 0);
  endtask
  task automatic drain();
    for (int k = 0; k < 200 && (sbq.size() != 0 || occ_m != 0); k++) tick();
    chk("drain_done", sbq.size() + occ_m, 0);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    sbq.delete();
    occ_m = 0;
    hold_v = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    foreach (in_data[i]) in_data[i] = '0;
    @(negedge clk);
    do_reset();
    arr = '{7, 6, 5, 4, 3, 2, 1, 0};
    send(1'b0);
    drain();
    send(1'b1);
    drain();
    arr = '{10, 11, 12, 13, 14, 15, 16, 17};
    send(1'b0);
    arr = '{20, 21, 22, 23, 24, 25, 26, 27};
    send(1'b1);
    arr = '{30, 31, 32, 33, 34, 35, 36, 37};
    send(1'b0);
    drain();
    bp = 1;
    arr = '{40, 41, 42, 43, 44, 45, 46, 47};
    send(1'b0);
    arr = '{50, 51, 52, 53, 54, 55, 56, 57};
    send(1'b1);
    drain();
    bp = 0;
    arr = '{60, 61, 62, 63, 64, 65, 66, 67};
    send(1'b0);
    repeat (7) tick();
    arr = '{70, 71, 72, 73, 74, 75, 76, 77};
    send(1'b1);
    drain();
    arr = '{80, 81, 82, 83, 84, 85, 86, 87};
    send(1'b0);
    arr = '{90, 91, 92, 93, 94, 95, 96, 97};
    send(1'b0);
    tick();
    tick();
    do_reset();
    arr = '{1, 2, 3, 4, 5, 6, 7, 8};
    send(1'b1);
    drain();
    bp = 2;
    repeat (6) begin
      foreach (arr[i]) arr[i] = 8'($urandom);
      send(1'($urandom_range(0, 1)));
    end
    drain();
    bp = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
